// File: rtl/uart_frame_sender_if.sv
// Result handshake and serial-transmitter signals of the UART frame sender.
interface uart_frame_sender_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] peak_index;
    logic [15:0] peak_value;
    logic [7:0]  tx_data;
    logic        tx_pluse;
    logic        tx_busy;
    logic        frame_done;
    logic        busy;

    // master supplies results and the transmitter status; slave is the frame sender
    modport master (
        output in_valid, peak_index, peak_value, tx_busy,
        input  in_ready, tx_data, tx_pluse, frame_done, busy
    );
    modport slave (
        input  in_valid, peak_index, peak_value, tx_busy,
        output in_ready, tx_data, tx_pluse, frame_done, busy
    );
endinterface

// File: rtl/uart_frame_sender.sv
// Sends a 7-byte peak report (two headers, index, value, checksum) one byte at a
// time through a pulse-triggered serial transmitter.
//
// state     | meaning
// IDLE      | waiting for a result, in_ready high
// PULSE     | tx_pluse held high for PULSE_LEN cycles
// WAIT_BUSY | waiting for the transmitter to take the byte
// WAIT_DONE | byte in flight, waiting for tx_busy to drop
// GAP       | spacing of GAP_CYCLES+1 cycles before the next byte
// LAST      | one-cycle frame_done
module uart_frame_sender #(
    parameter logic [7:0]  HEADER0    = 8'hAA,
    parameter logic [7:0]  HEADER1    = 8'h55,
    parameter int unsigned PULSE_LEN  = 2,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    uart_frame_sender_if.slave frm
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PULSE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;
    localparam logic [2:0] S_LAST      = 3'd5;

    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_LEN - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES);
    localparam logic [2:0] LAST_BYTE  = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] val_q, val_d;
    logic [7:0]  chk_q, chk_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_pluse_q, tx_pluse_d;
    logic        ready_q, ready_d;
    logic        busy_seen_q, busy_seen_d;
    logic [3:0]  pulse_cnt_q, pulse_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]  next_byte;

    always_comb begin
        next_byte = 8'h00;
        case (cnt_q)
            3'd0:    next_byte = HEADER0;
            3'd1:    next_byte = HEADER1;
            3'd2:    next_byte = idx_q[15:8];
            3'd3:    next_byte = idx_q[7:0];
            3'd4:    next_byte = val_q[15:8];
            3'd5:    next_byte = val_q[7:0];
            3'd6:    next_byte = chk_q;
            default: next_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        val_d       = val_q;
        chk_d       = chk_q;
        tx_data_d   = tx_data_q;
        tx_pluse_d  = tx_pluse_q;
        busy_seen_d = busy_seen_q;
        pulse_cnt_d = pulse_cnt_q;
        gap_cnt_d   = gap_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (frm.in_valid && ready_q) begin
                    idx_d       = frm.peak_index;
                    val_d       = frm.peak_value;
                    chk_d       = frm.peak_index[15:8] + frm.peak_index[7:0]
                                + frm.peak_value[15:8] + frm.peak_value[7:0];
                    cnt_d       = 3'd0;
                    tx_data_d   = HEADER0;
                    tx_pluse_d  = 1'b1;
                    pulse_cnt_d = PULSE_LOAD;
                    busy_seen_d = 1'b0;
                    state_d     = S_PULSE;
                end
            end
            S_PULSE: begin
                // a fast transmitter may already report busy while the pulse is high
                if (frm.tx_busy) busy_seen_d = 1'b1;
                if (pulse_cnt_q == 4'd0) begin
                    tx_pluse_d = 1'b0;
                    state_d    = S_WAIT_BUSY;
                end else begin
                    pulse_cnt_d = pulse_cnt_q - 4'd1;
                end
            end
            S_WAIT_BUSY: begin
                if (frm.tx_busy || busy_seen_q) begin
                    busy_seen_d = 1'b0;
                    state_d     = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!frm.tx_busy) begin
                    if (cnt_q == LAST_BYTE) begin
                        state_d = S_LAST;
                    end else begin
                        cnt_d     = cnt_q + 3'd1;
                        gap_cnt_d = GAP_LOAD;
                        state_d   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    tx_data_d   = next_byte;
                    tx_pluse_d  = 1'b1;
                    pulse_cnt_d = PULSE_LOAD;
                    busy_seen_d = 1'b0;
                    state_d     = S_PULSE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            S_LAST: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                tx_pluse_d = 1'b0;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            idx_q       <= 16'h0000;
            val_q       <= 16'h0000;
            chk_q       <= 8'h00;
            tx_data_q   <= 8'h00;
            tx_pluse_q  <= 1'b0;
            ready_q     <= 1'b0;
            busy_seen_q <= 1'b0;
            pulse_cnt_q <= 4'd0;
            gap_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            val_q       <= val_d;
            chk_q       <= chk_d;
            tx_data_q   <= tx_data_d;
            tx_pluse_q  <= tx_pluse_d;
            ready_q     <= ready_d;
            busy_seen_q <= busy_seen_d;
            pulse_cnt_q <= pulse_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign frm.in_ready   = ready_q;
    assign frm.tx_data    = tx_data_q;
    assign frm.tx_pluse   = tx_pluse_q;
    assign frm.frame_done = (state_q == S_LAST);
    assign frm.busy       = (state_q != S_IDLE);
endmodule

// File: doc/uart_frame_sender.md
UART_FRAME_SENDER -- requirements
Module: uart_frame_sender

Interface
REQ-001 Parameter HEADER0, default 8'hAA, first frame byte.
REQ-002 Parameter HEADER1, default 8'h55, second frame byte.
REQ-003 Parameter PULSE_LEN, default 2, tx_pluse high width in clk cycles; legal range 2-15.
REQ-004 Parameter GAP_CYCLES, default 2, idle clk cycles between tx_busy falling and the next tx_pluse rise; legal range 0-255.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rstn  input  1  reset; synchronous, active-low.
REQ-007 in_valid  input  1  result available on peak_index/peak_value.
REQ-008 in_ready  output  1  block can accept a result.
REQ-009 peak_index  input  16  peak position.
REQ-010 peak_value  input  16  peak amplitude.
REQ-011 tx_data  output  8  byte presented to the serial transmitter.
REQ-012 tx_pluse  output  1  send trigger to the transmitter; the rising edge is significant.
REQ-013 tx_busy  input  1  transmitter busy, high while a byte is in flight.
REQ-014 frame_done  output  1  one-cycle pulse when the last byte of a frame has completed.
REQ-015 busy  output  1  high whenever the block is not in IDLE.

Function
REQ-016 Frame SHALL be 7 bytes, in order: HEADER0, HEADER1, idx[15:8], idx[7:0], val[15:8], val[7:0], CHK.
REQ-017 CHK SHALL equal (idx[15:8]+idx[7:0]+val[15:8]+val[7:0]) mod 256; carries are discarded.
REQ-018 in_ready SHALL be 1 only in IDLE; in_valid while in_ready=0 SHALL be ignored, with nothing queued.
REQ-019 On the edge sampling in_valid=1 with in_ready=1:
  - capture idx and val;
  - register CHK;
  - clear the byte counter to 0;
  - load tx_data with HEADER0;
  - set tx_pluse=1;
  - enter PULSE.
REQ-020 States SHALL be IDLE, PULSE, WAIT_BUSY, WAIT_DONE, GAP, LAST.
REQ-021 PULSE: hold tx_pluse=1 for exactly PULSE_LEN cycles, then drive tx_pluse=0 and go to WAIT_BUSY.
REQ-022 WAIT_BUSY: go to WAIT_DONE on the first cycle tx_busy=1. A tx_busy=1 already sampled during PULSE SHALL satisfy this condition immediately.
REQ-023 WAIT_DONE: on the first cycle tx_busy=0, act on the byte counter:
  - counter=6: go to LAST;
  - otherwise: increment the counter and go to GAP.
REQ-024 GAP:
  - count GAP_CYCLES cycles;
  - then load tx_data with the byte selected by the counter and set tx_pluse=1;
  - enter PULSE.
  - With GAP_CYCLES=0, GAP SHALL last exactly 1 cycle.
REQ-025 tx_data SHALL stay constant from the tx_pluse rise until tx_busy falls for that byte.
REQ-026 LAST: assert frame_done=1 for one cycle, then go to IDLE. in_ready SHALL become 1 on the following cycle.
REQ-027 tx_pluse SHALL have exactly one rising edge per byte, i.e. 7 edges per frame, and SHALL be 0 in IDLE.
REQ-028 Byte counter SHALL be 3 bits wide and SHALL never exceed 6.
REQ-029 Changes on peak_index/peak_value during a frame SHALL NOT affect the frame being sent.

Reset
REQ-030 rstn=0 at a clock edge SHALL set, regardless of state, including mid-frame:
  - state = IDLE;
  - tx_pluse = 0;
  - tx_data = 8'h00;
  - frame_done = 0;
  - busy = 0;
  - byte counter = 0;
  - captured registers = 0.
REQ-031 in_ready SHALL be 0 while rstn=0 and SHALL become 1 on the first edge with rstn=1.
REQ-032 Frames aborted by reset SHALL NOT resume. Outputs SHALL remain at reset values until a new in_valid is accepted.

Verification
REQ-033 Bench SHALL drive tx_busy from a transmitter model that:
  - raises tx_busy 1 cycle after detecting the tx_pluse rising edge;
  - holds tx_busy for N cycles (N parameterised, e.g. 40).
REQ-034 Scenario 1: idx=16'h0123, val=16'h4567 -> bytes AA 55 01 23 45 67 D0 in order; 7 tx_pluse edges; exactly one frame_done pulse.
REQ-035 Scenario 2: idx=16'hFFFF, val=16'hFFFF -> CHK=8'hFC (wrap-around); bytes AA 55 FF FF FF FF FC.
REQ-036 Scenario 3: hold in_valid=1 continuously with data changing mid-frame:
  - only values captured at acceptance are sent;
  - the next frame starts only after frame_done, the cycle after in_ready returns to 1.
REQ-037 Scenario 4: GAP_CYCLES=2 and GAP_CYCLES=0 -> measured tx_busy-fall-to-tx_pluse-rise = 3 and 1 cycles respectively; tx_pluse high for PULSE_LEN cycles each time.
REQ-038 Scenario 5: assert rstn=0 for 1 cycle during byte 3 -> next cycle tx_pluse=0, tx_data=00, busy=0, in_ready=1 after release; a following frame with idx=0001, val=0002 sends AA 55 00 01 00 02 03.
REQ-039 Scenario 6: check throughout all scenarios that tx_data is stable from each tx_pluse rise to the corresponding tx_busy fall.
